multicycle_seq: RTL and testbench
=================================

// Module: multicycle_seq
// PURPOSE
//  Multi-cycle control sequencer: successor to the single-cycle processor top. Steps each instruction
//  through FETCH/DECODE/EXEC/MEM/WB and talks to IMEM/DMEM over req/ack handshakes, so memories may
//  insert wait states. It owns PC, IR and MDR and pulses the regfile write. Decode, ALU/FPU and WB
//  datapath are unchanged and attach to its inputs and outputs.
// PARAMETERS
//  ADDR_W    32  PC and memory address width
//  DATA_W    32  instruction and data word width
//  RESET_PC  0   PC value after reset
//  MAX_WAIT  15  max cycles to wait for an ack before ERROR (>=1)
//  CNT_W     16  retired-instruction counter width
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_ack     in   1       fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   DATA_W  fetched instruction
//  instr        out  DATA_W  latched IR, to decode
//  dec_mem_rd   in   1       decoded load
//  dec_mem_wr   in   1       decoded store
//  dec_wb_en    in   1       instruction writes a GP/FP register
//  dec_halt     in   1       decoded halt/trap
//  take_branch  in   1       branch taken or jump (valid in EXEC)
//  target       in   ADDR_W  branch/jump target (valid in EXEC)
//  dmem_req     out  1       data access request
//  dmem_we      out  1       store when 1, load when 0 (valid with dmem_req)
//  dmem_ack     in   1       data access complete
//  dmem_rdata   in   DATA_W  load data
//  mdr          out  DATA_W  latched load data, to WB mux
//  rf_we        out  1       one-cycle register write strobe
//  pc           out  ADDR_W  current instruction PC
//  pc_plus_8    out  ADDR_W  pc+8, JAL/JALR link value
//  halted       out  1       in HALT state
//  bus_err      out  1       in ERROR state
//  retired_cnt  out  CNT_W   retired instruction count
// BEHAVIOUR
//  Reset (reset=0, async): state=BOOT, pc=RESET_PC, instr=0, mdr=0, retired_cnt=0, wait_cnt=0.
//   All strobes (imem_req, dmem_req, dmem_we, rf_we) and halted/bus_err are 0.
//  Strobes and flags are combinational decodes of the registered state. imem_addr=pc at all times.
//  States and transitions (evaluated on each rising edge):
//   BOOT   -> FETCH unconditionally. Gives one idle cycle after reset release.
//   FETCH  imem_req=1. On imem_ack: instr<=imem_rdata, go to DECODE.
//          A zero-wait ack in the first FETCH cycle is legal, so min fetch is 1 cycle.
//   DECODE 1 cycle. dec_halt -> HALT. dec_mem_rd & dec_mem_wr -> ERROR. Otherwise -> EXEC.
//   EXEC   1 cycle. npc <= take_branch ? target : pc+4.
//          target[1:0]!=0 with take_branch -> ERROR.
//          Then: rd|wr -> MEM; else wb_en -> WB; else retire -> FETCH.
//   MEM    dmem_req=1, dmem_we=dec_mem_wr. On dmem_ack:
//          load: mdr<=dmem_rdata -> WB; store: retire -> FETCH.
//   WB     rf_we=1 for exactly this cycle; retire -> FETCH.
//   HALT   halted=1. Strobes are 0. Left only by reset.
//   ERROR  bus_err=1. Strobes are 0. Left only by reset.
//  Retire: pc<=npc and retired_cnt<=retired_cnt+1. Both wrap mod 2^ADDR_W and 2^CNT_W.
//  Handshake: req is held high until ack is sampled and stays stable meanwhile. Ack is ignored while req=0.
//  Timeout: wait_cnt clears on entry to FETCH/MEM and increments each cycle with no ack.
//   Ack on the cycle wait_cnt==MAX_WAIT still completes. No ack on that cycle -> ERROR.
//  Latency with zero-wait memories: ALU op = 4 cycles, store = 4, load = 5, no-writeback op = 3.
//  pc+4 and pc+8 wrap mod 2^ADDR_W.
//  Reset mid-transaction aborts it immediately. No partial IR/MDR/PC update is kept.
// TESTING
//  1 Zero-wait IMEM, ALU op at pc=0x0, dec_wb_en=1 -> rf_we one pulse in cycle 4 of instr; pc=0x4; retired_cnt=1.
//  2 Load with DMEM ack after 3 waits, dmem_rdata=0xDEADBEEF -> mdr=0xDEADBEEF, rf_we 1 pulse, dmem_req high 4 cycles.
//  3 Taken branch at pc=0x10, target=0x40 -> next imem_addr=0x40; misaligned target 0x42 -> bus_err=1, strobes 0.
//  4 IMEM never acks, MAX_WAIT=15 -> ERROR after 16 FETCH cycles; req drops; pc unchanged.
//  5 dec_halt -> halted=1, no further imem_req. Assert reset mid-MEM -> BOOT, pc=RESET_PC, dmem_req=0 at once.
//  6 pc=0xFFFFFFFC with no branch -> pc wraps to 0x0; CNT_W=4 after 16 retires -> retired_cnt=0; pc_plus_8 wraps.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshaking with IMEM/DMEM, and owns PC, IR, MDR and the retired-instruction counter.
module multicycle_seq #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15,
    parameter int                CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    input  logic              dec_mem_rd,
    input  logic              dec_mem_wr,
    input  logic              dec_wb_en,
    input  logic              dec_halt,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] target,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] mdr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_8,
    output logic              halted,
    output logic              bus_err,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int                WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] npc_reg, npc_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;

    logic [ADDR_W-1:0] pc_plus_4;
    logic [ADDR_W-1:0] exec_npc;
    logic [ADDR_W-1:0] retire_pc;
    logic              wait_expired;
    logic              retire;

    assign pc_plus_4    = pc_reg + ADDR_W'(4);
    assign exec_npc     = take_branch ? target : pc_plus_4;
    // A no-writeback op retires straight out of EXEC, before npc_reg has been loaded.
    assign retire_pc    = (state_reg == S_EXEC) ? exec_npc : npc_reg;
    assign wait_expired = (wait_reg == WAIT_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_BOOT;
            pc_reg    <= RESET_PC;
            npc_reg   <= RESET_PC;
            instr_reg <= '0;
            mdr_reg   <= '0;
            cnt_reg   <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            npc_reg   <= npc_next;
            instr_reg <= instr_next;
            mdr_reg   <= mdr_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        npc_next   = npc_reg;
        instr_next = instr_reg;
        mdr_next   = mdr_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        retire     = 1'b0;

        case (state_reg)
            S_BOOT: begin
                state_next = S_FETCH;
                wait_next  = '0;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_halt) begin
                    state_next = S_HALT;
                end else if (dec_mem_rd && dec_mem_wr) begin
                    state_next = S_ERROR;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                npc_next = exec_npc;
                if (take_branch && (target[1:0] != 2'b00)) begin
                    state_next = S_ERROR;
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_next = S_MEM;
                    wait_next  = '0;
                end else if (dec_wb_en) begin
                    state_next = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dec_mem_wr) begin
                        retire = 1'b1;
                    end else begin
                        mdr_next   = dmem_rdata;
                        state_next = S_WB;
                    end
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            default: begin
                state_next = state_reg;
            end
        endcase

        if (retire) begin
            pc_next    = retire_pc;
            cnt_next   = cnt_reg + 1'b1;
            state_next = S_FETCH;
            wait_next  = '0;
        end
    end

    assign imem_req    = (state_reg == S_FETCH);
    assign dmem_req    = (state_reg == S_MEM);
    assign dmem_we     = (state_reg == S_MEM) && dec_mem_wr;
    assign rf_we       = (state_reg == S_WB);
    assign halted      = (state_reg == S_HALT);
    assign bus_err     = (state_reg == S_ERROR);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc_plus_8   = pc_reg + ADDR_W'(8);
    assign instr       = instr_reg;
    assign mdr         = mdr_reg;
    assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: a per-instruction phase model predicts every cycle's outputs,
// and literal checks pin key architectural results.
module tb_multicycle_seq;

    localparam int MAX_WAIT = 15;
    localparam int CW       = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req, imem_ack;
    logic [31:0]   imem_addr, imem_rdata, instr;
    logic          dec_mem_rd, dec_mem_wr, dec_wb_en, dec_halt, take_branch;
    logic [31:0]   target;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [31:0]   dmem_rdata, mdr, pc, pc_plus_8;
    logic          rf_we, halted, bus_err;
    logic [CW-1:0] retired_cnt;

    multicycle_seq #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr),
        .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_wb_en(dec_wb_en), .dec_halt(dec_halt),
        .take_branch(take_branch), .target(target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mdr(mdr), .rf_we(rf_we), .pc(pc), .pc_plus_8(pc_plus_8),
        .halted(halted), .bus_err(bus_err), .retired_cnt(retired_cnt)
    );

    always #5 clock = ~clock;

    // Architectural model state and the strobes expected in the current cycle.
    logic [31:0]   m_pc, m_instr, m_mdr;
    logic [CW-1:0] m_cnt;
    logic          m_halt, m_err;
    logic          e_ireq, e_dreq, e_dwe, e_rfwe;
    logic          chk_en = 1'b0;
    int            n_cmp = 0, n_bad = 0;
    int            n_dreq = 0, n_rfwe = 0, n_ireq = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp("imem_req", {31'b0, imem_req}, {31'b0, e_ireq});
            cmp("dmem_req", {31'b0, dmem_req}, {31'b0, e_dreq});
            cmp("dmem_we", {31'b0, dmem_we}, {31'b0, e_dwe});
            cmp("rf_we", {31'b0, rf_we}, {31'b0, e_rfwe});
            cmp("halted", {31'b0, halted}, {31'b0, m_halt});
            cmp("bus_err", {31'b0, bus_err}, {31'b0, m_err});
            cmp("pc", pc, m_pc);
            cmp("imem_addr", imem_addr, m_pc);
            cmp("pc_plus_8", pc_plus_8, m_pc + 32'd8);
            cmp("instr", instr, m_instr);
            cmp("mdr", mdr, m_mdr);
            cmp("retired_cnt", {28'b0, retired_cnt}, {28'b0, m_cnt});
            $display("cycle t=%0t pc=%h ireq=%b dreq=%b we=%b rf_we=%b halt=%b err=%b cnt=%0d",
                     $time, pc, imem_req, dmem_req, dmem_we, rf_we, halted, bus_err, retired_cnt);
            if (dmem_req) n_dreq++;
            if (rf_we)    n_rfwe++;
            if (imem_req) n_ireq++;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input logic ireq, input logic dreq, input logic dwe, input logic rfwe);
        e_ireq = ireq;
        e_dreq = dreq;
        e_dwe  = dwe;
        e_rfwe = rfwe;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {imem_ack, dmem_ack, dec_mem_rd, dec_mem_wr, dec_wb_en, dec_halt, take_branch} = '0;
        imem_rdata = '0; dmem_rdata = '0; target = '0;
        m_pc = 32'h0; m_instr = '0; m_mdr = '0; m_cnt = '0; m_halt = 1'b0; m_err = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        idle(1);   // boot cycle
    endtask

    // One instruction: waits are ack delays (beyond MAX_WAIT means never), abort_mem>=0 leaves mid-MEM.
    task automatic run_instr(input logic rd, input logic wr, input logic wb, input logic hlt,
                             input logic br, input logic [31:0] tgt, input logic [31:0] word,
                             input logic [31:0] ldata, input int iw, input int dw, input int abort_mem);
        logic [31:0] npc;
        dec_mem_rd = rd; dec_mem_wr = wr; dec_wb_en = wb; dec_halt = hlt;
        take_branch = br; target = tgt; imem_rdata = word; dmem_rdata = ldata;
        for (int w = 0; w <= MAX_WAIT; w++) begin
            imem_ack = (w == iw);
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
            next_cycle();
            if (w == iw) break;
        end
        imem_ack = 1'b0;
        if (iw > MAX_WAIT) begin m_err = 1'b1; return; end
        m_instr = word;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);   // decode
        next_cycle();
        if (hlt)       begin m_halt = 1'b1; return; end
        if (rd && wr)  begin m_err = 1'b1;  return; end
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);   // execute
        next_cycle();
        if (br && (tgt[1:0] != 2'b00)) begin m_err = 1'b1; return; end
        npc = br ? tgt : m_pc + 32'd4;
        if (rd || wr) begin
            for (int w = 0; w <= MAX_WAIT; w++) begin
                if (w == abort_mem) return;
                dmem_ack = (w == dw);
                set_exp(1'b0, 1'b1, wr, 1'b0);
                next_cycle();
                if (w == dw) break;
            end
            dmem_ack = 1'b0;
            if (dw > MAX_WAIT) begin m_err = 1'b1; return; end
            if (rd) m_mdr = ldata;
        end
        if (rd || (!wr && wb)) begin
            set_exp(1'b0, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        m_pc  = npc;
        m_cnt = m_cnt + 1'b1;
    endtask

    initial begin
        {imem_ack, dmem_ack, dec_mem_rd, dec_mem_wr, dec_wb_en, dec_halt, take_branch} = '0;
        imem_rdata = '0; dmem_rdata = '0; target = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        do_reset();

        // ALU op, zero-wait fetch
        n_rfwe = 0;
        run_instr(0, 0, 1, 0, 0, 32'h0, 32'h1111_1111, 32'h0, 0, 0, -1);
        cmp("lit_t1_pc", pc, 32'h4);
        cmp("lit_t1_cnt", {28'b0, retired_cnt}, 32'd1);
        cmp("lit_t1_rfwe", n_rfwe, 32'd1);

        // load with three DMEM wait states
        n_rfwe = 0; n_dreq = 0;
        run_instr(1, 0, 1, 0, 0, 32'h0, 32'h2222_2222, 32'hDEAD_BEEF, 1, 3, -1);
        cmp("lit_t2_mdr", mdr, 32'hDEAD_BEEF);
        cmp("lit_t2_dreq", n_dreq, 32'd4);
        cmp("lit_t2_rfwe", n_rfwe, 32'd1);
        cmp("lit_t2_pc", pc, 32'h8);

        run_instr(0, 1, 0, 0, 0, 32'h0, 32'h3333_3333, 32'h5555_5555, 2, 0, -1);   // store
        cmp("lit_t3_pc", pc, 32'hC);
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h4444_4444, 32'h0, 0, 0, -1);           // no writeback
        cmp("lit_t4_pc", pc, 32'h10);
        run_instr(0, 0, 0, 0, 1, 32'h40, 32'h5555_0000, 32'h0, 0, 0, -1);          // taken branch
        cmp("lit_t5_addr", imem_addr, 32'h40);
        run_instr(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h6666_6666, 32'h0, 1, 0, -1);   // jump to top
        cmp("lit_t6_pc", pc, 32'hFFFF_FFFC);
        cmp("lit_t6_pc8", pc_plus_8, 32'h4);
        run_instr(0, 0, 1, 0, 0, 32'h0, 32'h7777_7777, 32'h0, 0, 0, -1);           // pc wraps
        cmp("lit_t7_pc", pc, 32'h0);

        for (int i = 0; i < 9; i++)
            run_instr(0, 0, 0, 0, 0, 32'h0, 32'h1000 + i, 32'h0, i % 3, 0, -1);
        cmp("lit_cnt_wrap", {28'b0, retired_cnt}, 32'd0);
        cmp("lit_cnt_pc", pc, 32'h24);

        // misaligned branch target
        run_instr(0, 0, 0, 0, 1, 32'h42, 32'h8888_8888, 32'h0, 0, 0, -1);
        idle(3);
        cmp("lit_mis_err", {31'b0, bus_err}, 32'd1);
        cmp("lit_mis_pc", pc, 32'h24);

        // IMEM never acks
        do_reset();
        n_ireq = 0;
        run_instr(0, 0, 1, 0, 0, 32'h0, 32'h9999_9999, 32'h0, 99, 0, -1);
        idle(2);
        cmp("lit_ito_req", n_ireq, 32'd16);
        cmp("lit_ito_err", {31'b0, bus_err}, 32'd1);
        cmp("lit_ito_pc", pc, 32'h0);

        // halt
        do_reset();
        run_instr(0, 0, 0, 1, 0, 32'h0, 32'hAAAA_AAAA, 32'h0, 0, 0, -1);
        n_ireq = 0;
        idle(4);
        cmp("lit_halt", {31'b0, halted}, 32'd1);
        cmp("lit_halt_ireq", n_ireq, 32'd0);

        // load and store decoded together
        do_reset();
        run_instr(1, 1, 0, 0, 0, 32'h0, 32'hBBBB_BBBB, 32'h0, 0, 0, -1);
        idle(2);
        cmp("lit_rdwr_err", {31'b0, bus_err}, 32'd1);

        // DMEM never acks
        do_reset();
        n_dreq = 0;
        run_instr(0, 1, 0, 0, 0, 32'h0, 32'hCCCC_CCCC, 32'h0, 0, 99, -1);
        idle(2);
        cmp("lit_dto_req", n_dreq, 32'd16);
        cmp("lit_dto_err", {31'b0, bus_err}, 32'd1);

        // reset in the middle of a load
        do_reset();
        run_instr(0, 0, 1, 0, 0, 32'h0, 32'hDDDD_DDDD, 32'h0, 0, 0, -1);
        run_instr(1, 0, 1, 0, 0, 32'h0, 32'hEEEE_EEEE, 32'hCAFE_F00D, 0, 9, 2);
        reset = 1'b0;
        #1;
        cmp("lit_abort_dreq", {31'b0, dmem_req}, 32'd0);
        cmp("lit_abort_pc", pc, 32'h0);
        cmp("lit_abort_instr", instr, 32'h0);
        cmp("lit_abort_mdr", mdr, 32'h0);
        do_reset();
        run_instr(0, 0, 1, 0, 0, 32'h0, 32'h1234_5678, 32'h0, 0, 0, -1);
        cmp("lit_recover_pc", pc, 32'h4);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
